// File: rtl/alu_cmd_issue_pkg.sv
// Shared definitions for the ALU command front-end: opcodes, flag bit positions
// and the packed command word that travels through the FIFO.
package alu_cmd_issue_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_LESS = 3'b110;
    localparam logic [2:0] OP_EQ   = 3'b111;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVER = 1;
    localparam int FLG_COUT = 2;
    localparam int FLG_LESS = 3;

    localparam int CMD_W = 11;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    // Only add and subtract produce a meaningful signed overflow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_issue_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable when the indices match.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         push_en_s;
    logic         pop_en_s;

    // Status flags, qualified push/pop and next pointer/storage state.
    always_comb begin
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        push_en_s = push && !full;
        pop_en_s  = pop && !empty;
        head      = mem_q[rd_ptr_q[AW-1:0]];
        mem_d     = mem_q;
        if (push_en_s) begin
            wr_ptr_d                    = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            mem_d[wr_ptr_q[AW-1:0]]     = din;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_en_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front-end for the 4-bit ALU: queues commands, drives the ALU from the
// FIFO head, captures results into a valid/ready slot and counts overflows.
module alu_cmd_issue
    import alu_cmd_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_ch,
    input  logic [3:0]       alu_f,
    input  logic             alu_zero,
    input  logic             alu_over,
    input  logic             alu_cout,
    input  logic             alu_less,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_f,
    output logic [3:0]       res_flags,
    output logic [2:0]       res_op,
    output logic [CNT_W-1:0] ovf_cnt
);

    cmd_t             cmd_in_s;
    cmd_t             head_s;
    logic             full_s;
    logic             empty_s;
    logic             issue_s;

    logic             res_valid_q, res_valid_d;
    logic [3:0]       res_f_q,     res_f_d;
    logic [3:0]       res_flags_q, res_flags_d;
    logic [2:0]       res_op_q,    res_op_d;
    logic [CNT_W-1:0] ovf_cnt_q,   ovf_cnt_d;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (issue_s),
        .din   (cmd_in_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Issue decision, ALU drive and next result-slot / counter state.
    always_comb begin
        cmd_in_s.a  = cmd_a;
        cmd_in_s.b  = cmd_b;
        cmd_in_s.op = cmd_op;
        cmd_ready   = !full_s;
        issue_s     = !empty_s && (!res_valid_q || res_ready);

        if (empty_s) begin
            alu_a  = 4'd0;
            alu_b  = 4'd0;
            alu_ch = 3'b000;
        end else begin
            alu_a  = head_s.a;
            alu_b  = head_s.b;
            alu_ch = head_s.op;
        end

        res_valid_d = res_valid_q;
        res_f_d     = res_f_q;
        res_flags_d = res_flags_q;
        res_op_d    = res_op_q;
        ovf_cnt_d   = ovf_cnt_q;

        // A new result overwrites the slot in the same cycle the old one is taken.
        if (issue_s) begin
            res_valid_d           = 1'b1;
            res_f_d               = alu_f;
            res_flags_d[FLG_ZERO] = alu_zero;
            res_flags_d[FLG_OVER] = alu_over;
            res_flags_d[FLG_COUT] = alu_cout;
            res_flags_d[FLG_LESS] = alu_less;
            res_op_d              = head_s.op;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        if (issue_s && is_arith(head_s.op) && alu_over && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Result slot and overflow counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_f_q     <= 4'd0;
            res_flags_q <= 4'd0;
            res_op_q    <= 3'b000;
            ovf_cnt_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_f_q     <= res_f_d;
            res_flags_q <= res_flags_d;
            res_op_q    <= res_op_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_f     = res_f_q;
    assign res_flags = res_flags_q;
    assign res_op    = res_op_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural 4-bit ALU on the alu_* ports.
module tb_alu_cmd_issue;
    import alu_cmd_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_ch;
    logic [3:0] alu_f;
    logic       alu_zero, alu_over, alu_cout, alu_less;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_f, res_flags;
    logic [2:0] res_op;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_issue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ch    (alu_ch),
        .alu_f     (alu_f),
        .alu_zero  (alu_zero),
        .alu_over  (alu_over),
        .alu_cout  (alu_cout),
        .alu_less  (alu_less),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_flags (res_flags),
        .res_op    (res_op),
        .ovf_cnt   (ovf_cnt)
    );

    // Behavioural ALU: adder path adds for op 000, subtracts otherwise.
    logic [3:0] bb_s;
    logic [4:0] sum_s;
    always_comb begin
        bb_s     = (alu_ch == OP_ADD) ? alu_b : ~alu_b;
        sum_s    = {1'b0, alu_a} + {1'b0, bb_s} + ((alu_ch == OP_ADD) ? 5'd0 : 5'd1);
        alu_cout = sum_s[4];
        alu_over = (alu_a[3] == bb_s[3]) && (sum_s[3] != alu_a[3]);
        alu_less = ($signed(alu_a) < $signed(alu_b));
        case (alu_ch)
            OP_ADD, OP_SUB: alu_f = sum_s[3:0];
            OP_AND:         alu_f = alu_a & alu_b;
            OP_OR:          alu_f = alu_a | alu_b;
            OP_XOR:         alu_f = alu_a ^ alu_b;
            OP_LESS:        alu_f = {3'b000, alu_less};
            OP_EQ:          alu_f = {3'b000, (alu_a == alu_b)};
            default:        alu_f = 4'd0;
        endcase
        alu_zero = (alu_f == 4'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for one edge, confirm no result yet, then let the result land.
    task automatic push_and_get(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op;
        tick();
        cmd_valid = 1'b0;
        check_eq("latency_not_yet", {31'd0, res_valid}, 32'd0);
        tick();
    endtask

    logic [10:0] vec [5];
    logic [3:0]  vexp [5];
    int          bad;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 3'b000;
        res_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        check_eq("rst_res_f", {28'd0, res_f}, 32'd0);
        check_eq("rst_alu_ch", {29'd0, alu_ch}, 32'd0);

        // 3 + 5: signed overflow, no carry, 3 < 5.
        push_and_get(4'd3, 4'd5, OP_ADD);
        check_eq("add_valid", {31'd0, res_valid}, 32'd1);
        check_eq("add_f", {28'd0, res_f}, 32'd8);
        check_eq("add_flags", {28'd0, res_flags}, 32'hA);
        check_eq("add_op", {29'd0, res_op}, 32'd0);
        check_eq("add_ovf", {24'd0, ovf_cnt}, 32'd1);

        // 5 - 5: zero, carry out (no borrow).
        push_and_get(4'd5, 4'd5, OP_SUB);
        check_eq("sub_f", {28'd0, res_f}, 32'd0);
        check_eq("sub_flags", {28'd0, res_flags}, 32'h5);
        check_eq("sub_ovf", {24'd0, ovf_cnt}, 32'd1);

        // -4 < 3.
        push_and_get(4'hC, 4'd3, OP_LESS);
        check_eq("less_f", {28'd0, res_f}, 32'd1);
        check_eq("less_flags", {28'd0, res_flags}, 32'hC);
        check_eq("less_op", {29'd0, res_op}, 32'd6);

        // -8 - 1 overflows and is counted.
        push_and_get(4'h8, 4'd1, OP_SUB);
        check_eq("subovf_f", {28'd0, res_f}, 32'd7);
        check_eq("subovf_flags", {28'd0, res_flags}, 32'hE);
        check_eq("subovf_cnt", {24'd0, ovf_cnt}, 32'd2);

        // Fill with consumer stalled: one result held plus four queued.
        vec[0] = {4'd1, 4'd1, OP_ADD}; vexp[0] = 4'd2;
        vec[1] = {4'd2, 4'd3, OP_ADD}; vexp[1] = 4'd5;
        vec[2] = {4'd6, 4'd3, OP_AND}; vexp[2] = 4'd2;
        vec[3] = {4'd9, 4'd6, OP_OR};  vexp[3] = 4'hF;
        vec[4] = {4'd5, 4'hF, OP_XOR}; vexp[4] = 4'hA;
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("fill_ready", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b1;
            {cmd_a, cmd_b, cmd_op} = vec[i];
            tick();
        end
        cmd_a = 4'd7; cmd_b = 4'd7; cmd_op = OP_EQ;
        check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
        tick(); tick();
        check_eq("stall_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("stall_valid", {31'd0, res_valid}, 32'd1);
        check_eq("stall_f", {28'd0, res_f}, 32'd2);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_valid", {31'd0, res_valid}, 32'd1);
            check_eq("drain_f", {28'd0, res_f}, {28'd0, vexp[i]});
            tick();
        end
        check_eq("drain_done", {31'd0, res_valid}, 32'd0);
        check_eq("drain_ovf", {24'd0, ovf_cnt}, 32'd2);

        // 300 overflowing adds saturate the counter.
        cmd_valid = 1'b1; cmd_a = 4'd7; cmd_b = 4'd1; cmd_op = OP_ADD;
        for (int i = 0; i < 300; i++) tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("ovf_sat", {24'd0, ovf_cnt}, 32'd255);

        // Reset with a held result and three queued commands.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2; cmd_op = OP_OR;
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mid_rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        check_eq("mid_rst_alu_ch", {29'd0, alu_ch}, 32'd0);
        check_eq("mid_rst_alu_a", {28'd0, alu_a}, 32'd0);
        res_ready = 1'b1;
        push_and_get(4'd2, 4'd2, OP_ADD);
        check_eq("post_rst_valid", {31'd0, res_valid}, 32'd1);
        check_eq("post_rst_f", {28'd0, res_f}, 32'd4);
        tick();
        check_eq("post_rst_no_stale", {31'd0, res_valid}, 32'd0);

        // Illegal opcode passes through and is never counted.
        push_and_get(4'd3, 4'd3, 3'b010);
        check_eq("illegal_f", {28'd0, res_f}, 32'd0);
        check_eq("illegal_op", {29'd0, res_op}, 32'd2);
        check_eq("illegal_ovf", {24'd0, ovf_cnt}, 32'd0);
        tick();

        // Idle with a random consumer: nothing may appear.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            res_ready = 1'($urandom_range(0, 1));
            tick();
            if (res_valid !== 1'b0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_ch !== 3'd0)
                bad++;
        end
        check_eq("idle_quiet", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
